pattern_sequencer: RTL

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_sequencer_pkg.sv | 44 ++++
 rtl/pattern_sequencer_if.sv | 38 +++
 rtl/pattern_sequencer_frame_timer.sv | 36 +++
 rtl/pattern_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pattern_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared types and constants for the test-pattern sequencer: pattern-id width,
// the index of each built-in pattern, the sequencer state encoding and the
// pending-step encoding, plus a wrap-around step helper.
// -----------------------------------------------------------------------------
package pattern_pkg;

   localparam int PATTERN_ID_W = 3;

   typedef logic [PATTERN_ID_W-1:0] pattern_id_t;

   // Pattern indices understood by the pixel generator.
   localparam pattern_id_t COLORBAR = 3'd0;
   localparam pattern_id_t RED      = 3'd1;
   localparam pattern_id_t GREEN    = 3'd2;
   localparam pattern_id_t GRID     = 3'd3;
   localparam pattern_id_t GRID_ALT = 3'd4;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      MANUAL    = 2'd1,
      AUTO      = 2'd2
   } seq_state_t;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_NEXT = 2'd1,
      STEP_PREV = 2'd2
   } step_t;

   // Move one pattern forward or back, wrapping between 0 and last.
   function automatic pattern_id_t step_id(pattern_id_t id, step_t dir, pattern_id_t last);
      pattern_id_t result;
      result = id;
      case (dir)
         STEP_NEXT: result = (id == last) ? '0 : id + pattern_id_t'(1);
         STEP_PREV: result = (id == '0) ? last : id - pattern_id_t'(1);
         default:   result = id;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// -----------------------------------------------------------------------------
// pattern_sequencer_if
// Control/status bundle between the front-panel/timing logic (master) and the
// pattern sequencer (slave).
//   frame_start     : one-pclk pulse at the first blanking line of a frame
//   next_req        : debounced pulse, step to next pattern
//   prev_req        : debounced pulse, step to previous pattern
//   mode_req        : debounced pulse, toggle manual/auto
//   hold_frames     : auto-advance period in frames (0 = module default)
//   pattern_id      : active pattern index
//   auto_mode       : high while auto-advancing
//   pattern_changed : one-pclk pulse when pattern_id takes a new value
//   synced          : high once the first frame_start has been seen
// -----------------------------------------------------------------------------
interface pattern_sequencer_if;
   import pattern_pkg::*;

   logic        frame_start;
   logic        next_req;
   logic        prev_req;
   logic        mode_req;
   logic [15:0] hold_frames;
   pattern_id_t pattern_id;
   logic        auto_mode;
   logic        pattern_changed;
   logic        synced;

   modport master (
      output frame_start, next_req, prev_req, mode_req, hold_frames,
      input  pattern_id, auto_mode, pattern_changed, synced
   );

   modport slave (
      input  frame_start, next_req, prev_req, mode_req, hold_frames,
      output pattern_id, auto_mode, pattern_changed, synced
   );

endinterface

// File: rtl/pattern_sequencer_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// 16-bit frame counter for auto-advance. clear has priority over inc.
// tc is high when one more increment would reach (or pass) hold, so the owner
// advances on that frame_start instead of incrementing; a hold lowered below
// the current count therefore fires on the next frame.
//   pclk  : pixel clock
//   rst_n : asynchronous active-low reset
//   clear : zero the counter
//   inc   : increment the counter
//   hold  : effective hold period in frames (non-zero)
//   tc    : terminal-count flag
// -----------------------------------------------------------------------------
module frame_timer (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        inc,
   input  logic [15:0] hold,
   output logic        tc
);

   logic [15:0] count;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n)     count <= '0;
      else if (clear) count <= '0;
      else if (inc)   count <= count + 16'd1;
   end

   // 17-bit compare so count+1 cannot wrap at 16'hFFFF.
   assign tc = ({1'b0, count} + 17'd1) >= {1'b0, hold};

endmodule

// File: rtl/pattern_sequencer.sv
// -----------------------------------------------------------------------------
// pattern_sequencer
// Selects the active test pattern. Button requests are queued as pending and
// only applied on a frame_start edge so the picture never changes mid-frame.
// In AUTO the pattern also advances every hold frames.
//   pclk  : pixel clock, all logic on its rising edge
//   rst_n : asynchronous active-low reset, released synchronously internally
//   bus   : slave side of pattern_sequencer_if (requests in, status out)
// -----------------------------------------------------------------------------
module pattern_sequencer
   import pattern_pkg::*;
#(
   parameter int unsigned NUM_PATTERNS = 5,
   parameter logic [15:0] DEFAULT_HOLD = 16'd120
) (
   input  logic              pclk,
   input  logic              rst_n,
   pattern_sequencer_if.slave bus
);

   localparam pattern_id_t LAST_ID = pattern_id_t'(NUM_PATTERNS - 1);

   logic [1:0]  rst_sync;
   logic        rst_sync_n;

   seq_state_t  state, state_next;
   step_t       step_pend, step_pend_next;
   step_t       req_step;
   logic        mode_pend, mode_pend_next;
   pattern_id_t id, id_next;
   logic        changed;

   logic        timer_clear, timer_inc, timer_tc;
   logic [15:0] hold_eff;

   // NOTE: reset asserts asynchronously but releases on a clock edge, so no
   // flop sees rst_n rising close to pclk and leaves reset in a different cycle.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_sync_n = rst_sync[1];

   assign hold_eff = (bus.hold_frames == 16'd0) ? DEFAULT_HOLD : bus.hold_frames;

   frame_timer u_frame_timer (
      .pclk  (pclk),
      .rst_n (rst_sync_n),
      .clear (timer_clear),
      .inc   (timer_inc),
      .hold  (hold_eff),
      .tc    (timer_tc)
   );

   // Simultaneous next and prev cancel each other and latch nothing.
   always_comb begin
      req_step = STEP_NONE;
      if (bus.next_req && !bus.prev_req)      req_step = STEP_NEXT;
      else if (bus.prev_req && !bus.next_req) req_step = STEP_PREV;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_next     = state;
      step_pend_next = step_pend;
      mode_pend_next = mode_pend;
      id_next        = id;
      timer_clear    = 1'b0;
      timer_inc      = 1'b0;

      case (state)
         WAIT_SYNC: begin
            // Pending requests survive the first frame_start and are applied
            // on the one after it.
            if (bus.frame_start) state_next = MANUAL;
         end
         MANUAL, AUTO: begin
            if (bus.frame_start) begin
               if (step_pend != STEP_NONE) begin
                  // A manual step beats auto-advance and restarts the period.
                  id_next     = step_id(id, step_pend, LAST_ID);
                  timer_clear = 1'b1;
               end else if (state == AUTO) begin
                  if (timer_tc) begin
                     id_next     = step_id(id, STEP_NEXT, LAST_ID);
                     timer_clear = 1'b1;
                  end else begin
                     timer_inc = 1'b1;
                  end
               end
               if (mode_pend) begin
                  state_next  = (state == AUTO) ? MANUAL : AUTO;
                  timer_clear = 1'b1;
               end
               step_pend_next = STEP_NONE;
               mode_pend_next = 1'b0;
            end
         end
         default: state_next = WAIT_SYNC;
      endcase

      // Requests are latched after the frame_start consumption above, so one
      // coinciding with frame_start waits for the following frame.
      if (req_step != STEP_NONE) step_pend_next = req_step;
      if (bus.mode_req)          mode_pend_next = !mode_pend_next;
   end

   always_ff @(posedge pclk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state     <= WAIT_SYNC;
         step_pend <= STEP_NONE;
         mode_pend <= 1'b0;
         id        <= COLORBAR;
         changed   <= 1'b0;
      end else begin
         state     <= state_next;
         step_pend <= step_pend_next;
         mode_pend <= mode_pend_next;
         id        <= id_next;
         changed   <= (id_next != id);
      end
   end

   assign bus.pattern_id      = id;
   assign bus.auto_mode       = (state == AUTO);
   assign bus.synced          = (state != WAIT_SYNC);
   assign bus.pattern_changed = changed;

endmodule
